// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and helpers.
// Also used by sprite modules for screen bounds.
package vga_timing_pkg;

  localparam int CW = 10;

  typedef logic [CW-1:0] coord_t;

  localparam int H_VISIBLE_D = 640;
  localparam int H_FP_D      = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BP_D      = 48;
  localparam int V_VISIBLE_D = 480;
  localparam int V_FP_D      = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BP_D      = 33;

  function automatic int axis_total(
    input int vis,
    input int fp,
    input int sync,
    input int bp
  );
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one screen axis with
// registered sync/visible/zero decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  input  logic   en,
  output coord_t count,
  output logic   tc,
  output logic   sync_n,
  output logic   vis,
  output logic   zero
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);
  localparam coord_t VEND = coord_t'(VISIBLE);
  localparam coord_t SBEG = coord_t'(SYNC_START);
  localparam coord_t SEND = coord_t'(SYNC_END);

  coord_t nxt;

  assign tc = (count == LAST);

  always_comb begin
    nxt = count;
    if (en) begin
      nxt = tc ? '0 : count + coord_t'(1);
    end
  end

  // Decode the next value so flags line up with count.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      count  <= '0;
      sync_n <= 1'b1;
      vis    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      count  <= nxt;
      sync_n <= !(nxt >= SBEG && nxt < SEND);
      vis    <= (nxt < VEND);
      zero   <= (nxt == '0);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters,
// syncs, blanking and frame bookkeeping.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_D,
  parameter int H_FP      = H_FP_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int H_BP      = H_BP_D,
  parameter int V_VISIBLE = V_VISIBLE_D,
  parameter int V_FP      = V_FP_D,
  parameter int V_SYNC    = V_SYNC_D,
  parameter int V_BP      = V_BP_D
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL =
    axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  logic h_tc, h_sync_n, h_vis, h_zero;
  logic v_tc, v_sync_n, v_vis, v_zero;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FP),
    .SYNC_END   (H_VISIBLE + H_FP + H_SYNC)
  ) u_h (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .count   (DrawX),
    .tc      (h_tc),
    .sync_n  (h_sync_n),
    .vis     (h_vis),
    .zero    (h_zero)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FP),
    .SYNC_END   (V_VISIBLE + V_FP + V_SYNC)
  ) u_v (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .en      (h_tc),
    .count   (DrawY),
    .tc      (v_tc),
    .sync_n  (v_sync_n),
    .vis     (v_vis),
    .zero    (v_zero)
  );

  assign hs          = h_sync_n;
  assign vs          = v_sync_n;
  assign blank       = h_vis & v_vis;
  assign line_start  = h_zero;
  assign frame_start = h_zero & v_zero;

  // Both axes at terminal count: next pixel is (0,0).
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (h_tc && v_tc) begin
      frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_VISIBLE 640, visible pixels per line; H_FP 16, H front porch; H_SYNC 96, H sync width; H_BP 48, H back porch; V_VISIBLE 480, visible lines; V_FP 10, V front porch; V_SYNC 2, V sync width; V_BP 33, V back porch.
REQ-002 SHALL have ports:
- vga_clk  in  1  pixel clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- DrawX  out  10  current pixel column counter.
- DrawY  out  10  current line counter.
- hs  out  1  horizontal sync, active low.
- vs  out  1  vertical sync, active low.
- blank  out  1  1 = visible pixel, 0 = blanking (sprite renderers gate color with it).
- line_start  out  1  one-cycle pulse at DrawX==0.
- frame_start  out  1  one-cycle pulse at DrawX==0 and DrawY==0.
- frame_count  out  8  completed-frame counter.

Function
REQ-003 SHALL derive H_TOTAL = sum of H parameters (800) and V_TOTAL = sum of V parameters (525).
REQ-004 SHALL increment DrawX by 1 each vga_clk cycle, wrapping H_TOTAL-1 -> 0.
REQ-005 SHALL increment DrawY by 1 only on the cycle DrawX wraps, wrapping V_TOTAL-1 -> 0.
REQ-006 SHALL register hs, vs, blank, line_start and frame_start from next-state counter values, so every output describes the same (DrawX, DrawY) in the same cycle (zero relative latency).
REQ-007 SHALL assert blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-008 SHALL drive hs = 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-009 SHALL drive vs = 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491), for the full line widths, independent of DrawX.
REQ-010 SHALL pulse line_start for exactly one cycle whenever DrawX == 0.
REQ-011 SHALL pulse frame_start for exactly one cycle whenever DrawX == 0 and DrawY == 0, excluding the reset state.
REQ-012 SHALL increment frame_count in the same cycle frame_start is asserted, wrapping 255 -> 0 silently.
REQ-013 SHALL perform all compares on unextended 10-bit values; the counters never exceed 799/524 by construction.

Reset
REQ-014 SHALL, while reset_n == 0 at a rising edge, set DrawX=0, DrawY=0, hs=1, vs=1, blank=0, line_start=0, frame_start=0, frame_count=0.
REQ-015 SHALL, at the first rising edge with reset_n == 1, advance to DrawX=1, DrawY=0, blank=1; pixel (0,0) of the first frame after reset is not displayed.
REQ-016 SHALL, on reset asserted mid-frame or mid-sync, return to the REQ-014 state at the next edge, with no partial sync pulse extension.

Structure
REQ-017 SHALL take default timing constants and a derived H_TOTAL/V_TOTAL function from shared package vga_timing_pkg, also used by sprite modules for screen bounds.
REQ-018 SHALL instantiate sub-module vga_axis_counter twice (horizontal, vertical); each is a wrap counter with enable, terminal-count output and registered sync/visible decode.

Verification
REQ-019 Release reset, run 800 cycles -> DrawX sequence 1..799,0; DrawY increments to 1 on the wrap cycle; line_start asserts exactly once.
REQ-020 Run one full frame (420000 cycles) -> hs low exactly 96 cycles per line; vs low exactly 1600 consecutive cycles (2 lines) per frame; frame_start asserts once; frame_count = 1.
REQ-021 Count blank==1 cycles over one full frame -> exactly 307200; all have DrawX<640 and DrawY<480.
REQ-022 Assert reset_n=0 at DrawX=700, DrawY=490 (inside hs and vs low) -> next edge hs=1, vs=1, counters 0, frame_count 0.
REQ-023 Run 256 frames -> frame_count wraps to 0 on the 256th frame_start; no glitches on hs/vs at the frame boundary.
